// File: rtl/addr_decode_prog_pkg.sv
// addr_decode_prog_pkg: shared types and helpers for the programmable
// address decoder (decode status encoding, range overlap test).
package addr_decode_prog_pkg;

  typedef enum logic [1:0] {
    DEC_HIT,
    DEC_DEFAULT,
    DEC_ERROR
  } dec_status_e;

  // Two half-open ranges overlap only if both are non-empty and they intersect.
  function automatic logic range_overlap(
    input logic [63:0] start_a,
    input logic [63:0] end_a,
    input logic [63:0] start_b,
    input logic [63:0] end_b
  );
    return (start_a < end_a) && (start_b < end_b) &&
           (start_a < end_b) && (start_b < end_a);
  endfunction

endpackage

// File: rtl/addr_decode_prog_match.sv
// addr_decode_prog_match: combinational priority match of one address
// against a flattened rule table; the highest-numbered matching rule wins.
module addr_decode_prog_match
  import addr_decode_prog_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NoRules   = 4,
  parameter int unsigned IdxWidth  = 1
) (
  input  logic [AddrWidth-1:0]          addr_i,
  input  logic [NoRules-1:0]            en_i,
  input  logic [NoRules*AddrWidth-1:0]  start_i,
  input  logic [NoRules*AddrWidth-1:0]  end_i,
  input  logic [NoRules*IdxWidth-1:0]   idx_i,
  output logic                          hit_o,
  output logic [IdxWidth-1:0]           idx_o
);

  // Scan upward so a later (higher-numbered) match overrides earlier ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      if (en_i[r] &&
          (addr_i >= start_i[r*AddrWidth +: AddrWidth]) &&
          (addr_i <  end_i[r*AddrWidth +: AddrWidth])) begin
        hit_o = 1'b1;
        idx_o = idx_i[r*IdxWidth +: IdxWidth];
      end
    end
  end

endmodule

// File: rtl/addr_decode_prog.sv
// addr_decode_prog: runtime-programmable pipelined address decoder.
// Owns the rule table, the single response register and the overlap flag.
// Optional feature: define ADDR_DECODE_PROG_OVERLAP_CHECK_EN to enable the
// sticky cfg_overlap_o detector; otherwise cfg_overlap_o is tied to 0.
module addr_decode_prog
  import addr_decode_prog_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NoRules   = 4,
  parameter int unsigned NoIndices = 2,
  localparam int unsigned IdxWidth = $clog2(NoIndices),
  localparam int unsigned SelWidth = (NoRules > 1) ? $clog2(NoRules) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [SelWidth-1:0]   cfg_sel_i,
  input  logic                  cfg_en_i,
  input  logic [IdxWidth-1:0]   cfg_idx_i,
  input  logic [AddrWidth-1:0]  cfg_start_i,
  input  logic [AddrWidth-1:0]  cfg_end_i,
  input  logic                  en_default_idx_i,
  input  logic [IdxWidth-1:0]   default_idx_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [AddrWidth-1:0]  resp_addr_o,
  output logic [IdxWidth-1:0]   resp_idx_o,
  output logic                  resp_dec_valid_o,
  output logic                  resp_dec_error_o,
  output logic                  cfg_overlap_o
);

  typedef struct packed {
    logic                 en;
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;

  rule_t table_q [NoRules];

  logic [NoRules-1:0]           tbl_en;
  logic [NoRules*AddrWidth-1:0] tbl_start;
  logic [NoRules*AddrWidth-1:0] tbl_end;
  logic [NoRules*IdxWidth-1:0]  tbl_idx;

  logic                match_hit;
  logic [IdxWidth-1:0] match_idx;
  dec_status_e         dec_status;
  logic [IdxWidth-1:0] dec_idx;
  logic                accept;

  // Rule table: cleared on reset, one slot written per cfg_we_i; a selector
  // beyond the last slot matches no loop iteration and is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NoRules; r++) begin
        table_q[r] <= '0;
      end
    end else if (cfg_we_i) begin
      for (int unsigned r = 0; r < NoRules; r++) begin
        if (cfg_sel_i == SelWidth'(r)) begin
          table_q[r] <= '{en: cfg_en_i, idx: cfg_idx_i,
                          start_addr: cfg_start_i, end_addr: cfg_end_i};
        end
      end
    end
  end

  // Flatten the table for the match sub-module.
  always_comb begin
    tbl_en    = '0;
    tbl_start = '0;
    tbl_end   = '0;
    tbl_idx   = '0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      tbl_en[r]                           = table_q[r].en;
      tbl_start[r*AddrWidth +: AddrWidth] = table_q[r].start_addr;
      tbl_end[r*AddrWidth +: AddrWidth]   = table_q[r].end_addr;
      tbl_idx[r*IdxWidth +: IdxWidth]     = table_q[r].idx;
    end
  end

  addr_decode_prog_match #(
    .AddrWidth (AddrWidth),
    .NoRules   (NoRules),
    .IdxWidth  (IdxWidth)
  ) u_match (
    .addr_i  (req_addr_i),
    .en_i    (tbl_en),
    .start_i (tbl_start),
    .end_i   (tbl_end),
    .idx_i   (tbl_idx),
    .hit_o   (match_hit),
    .idx_o   (match_idx)
  );

  // Classify the match result and select the index to report.
  always_comb begin
    if (match_hit) begin
      dec_status = DEC_HIT;
    end else if (en_default_idx_i) begin
      dec_status = DEC_DEFAULT;
    end else begin
      dec_status = DEC_ERROR;
    end
    unique case (dec_status)
      DEC_HIT:     dec_idx = match_idx;
      DEC_DEFAULT: dec_idx = default_idx_i;
      default:     dec_idx = '0;
    endcase
  end

  assign req_ready_o = !resp_valid_o || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Response register: load on accept, clear on a pop without accept,
  // otherwise hold so outputs stay stable under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o     <= 1'b0;
      resp_addr_o      <= '0;
      resp_idx_o       <= '0;
      resp_dec_valid_o <= 1'b0;
      resp_dec_error_o <= 1'b0;
    end else if (accept) begin
      resp_valid_o     <= 1'b1;
      resp_addr_o      <= req_addr_i;
      resp_idx_o       <= dec_idx;
      resp_dec_valid_o <= (dec_status == DEC_HIT);
      resp_dec_error_o <= (dec_status == DEC_ERROR);
    end else if (resp_ready_i) begin
      resp_valid_o     <= 1'b0;
    end
  end

`ifdef ADDR_DECODE_PROG_OVERLAP_CHECK_EN
  logic overlap_hit;
  logic sel_in_range;
  logic overlap_q;

  // Compare the incoming rule against every other enabled slot as stored now.
  always_comb begin
    overlap_hit  = 1'b0;
    sel_in_range = 1'b0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      if (cfg_sel_i == SelWidth'(r)) begin
        sel_in_range = 1'b1;
      end else if (table_q[r].en &&
                   range_overlap(64'(cfg_start_i), 64'(cfg_end_i),
                                 64'(table_q[r].start_addr),
                                 64'(table_q[r].end_addr))) begin
        overlap_hit = 1'b1;
      end
    end
  end

  // Sticky overlap flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overlap_q <= 1'b0;
    end else if (cfg_we_i && cfg_en_i && sel_in_range && overlap_hit) begin
      overlap_q <= 1'b1;
    end
  end

  assign cfg_overlap_o = overlap_q;
`else
  assign cfg_overlap_o = 1'b0;
`endif

endmodule

// File: tb/tb_addr_decode_prog.sv
// tb_addr_decode_prog: directed bench with a rule-list reference model,
// a per-cycle scoreboard compare process and literal spot checks.
module tb_addr_decode_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic        cfg_en;
  logic [0:0]  cfg_idx;
  logic [11:0] cfg_start;
  logic [11:0] cfg_end;
  logic        en_def;
  logic [0:0]  def_idx;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_addr;
  logic [0:0]  resp_idx;
  logic        resp_dv;
  logic        resp_de;
  logic        cfg_overlap;

  addr_decode_prog #(
    .AddrWidth (12),
    .NoRules   (3),
    .NoIndices (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_we_i         (cfg_we),
    .cfg_sel_i        (cfg_sel),
    .cfg_en_i         (cfg_en),
    .cfg_idx_i        (cfg_idx),
    .cfg_start_i      (cfg_start),
    .cfg_end_i        (cfg_end),
    .en_default_idx_i (en_def),
    .default_idx_i    (def_idx),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_addr_o      (resp_addr),
    .resp_idx_o       (resp_idx),
    .resp_dec_valid_o (resp_dv),
    .resp_dec_error_o (resp_de),
    .cfg_overlap_o    (cfg_overlap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_pops = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the rule list as plain arrays.
  typedef struct {
    logic [11:0] addr;
    logic        idx;
    logic        dv;
    logic        de;
  } resp_t;

  logic [11:0] m_start [3];
  logic [11:0] m_end   [3];
  logic        m_en    [3];
  logic        m_idx   [3];
  logic        m_ov;
  resp_t       q [$];

  function automatic resp_t model_decode(input logic [11:0] a, input logic ed, input logic di);
    resp_t r;
    r.addr = a;
    r.idx  = ed ? di : 1'b0;
    r.dv   = 1'b0;
    r.de   = !ed;
    for (int k = 2; k >= 0; k--) begin
      if (m_en[k] && a >= m_start[k] && a < m_end[k]) begin
        r.idx = m_idx[k];
        r.dv  = 1'b1;
        r.de  = 1'b0;
        return r;
      end
    end
    return r;
  endfunction

  // Compare process: runs once per cycle, away from the rising edge.
  always @(negedge clk) begin
    logic  exp_ready;
    int    sel;
    resp_t e;
    #2;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        m_en[k] = 1'b0; m_idx[k] = 1'b0; m_start[k] = '0; m_end[k] = '0;
      end
      m_ov = 1'b0;
    end else begin
      exp_ready = (q.size() == 0) || resp_ready;
      check("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
`ifdef ADDR_DECODE_PROG_OVERLAP_CHECK_EN
      check("cfg_overlap", 32'(cfg_overlap), 32'(m_ov));
`else
      check("cfg_overlap", 32'(cfg_overlap), 32'(0));
`endif
      if (q.size() != 0) begin
        e = q[0];
        check("resp_addr", 32'(resp_addr), 32'(e.addr));
        check("resp_idx", 32'(resp_idx), 32'(e.idx));
        check("resp_dec_valid", 32'(resp_dv), 32'(e.dv));
        check("resp_dec_error", 32'(resp_de), 32'(e.de));
        if (resp_ready) begin
          void'(q.pop_front());
          n_pops++;
        end
      end
      if (req_valid && exp_ready) q.push_back(model_decode(req_addr, en_def, def_idx[0]));
      sel = int'(cfg_sel);
      if (cfg_we && sel < 3) begin
        if (cfg_en) begin
          for (int k = 0; k < 3; k++) begin
            if (k != sel && m_en[k] && cfg_start < cfg_end && m_start[k] < m_end[k] &&
                cfg_start < m_end[k] && m_start[k] < cfg_end) m_ov = 1'b1;
          end
        end
        m_en[sel] = cfg_en; m_idx[sel] = cfg_idx[0];
        m_start[sel] = cfg_start; m_end[sel] = cfg_end;
      end
    end
  end

  task automatic write_rule(input int sel, input logic en, input logic idx,
                            input logic [11:0] s, input logic [11:0] e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_en = en; cfg_idx = idx;
    cfg_start = s; cfg_end = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    p0;
    resp_t mr;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0; cfg_idx = '0;
    cfg_start = '0; cfg_end = '0; en_def = 1'b0; def_idx = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("rst resp_valid", 32'(resp_valid), 32'(0));
    check("rst req_ready", 32'(req_ready), 32'(1));
    check("rst resp_addr", 32'(resp_addr), 32'(0));
    check("rst resp_flags", 32'({resp_idx, resp_dv, resp_de}), 32'(0));
    check("rst overlap", 32'(cfg_overlap), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Empty table: miss without default is an error.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h005;
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    check("empty valid", 32'(resp_valid), 32'(1));
    check("empty error", 32'({resp_de, resp_dv, resp_idx}), 32'(3'b100));

    write_rule(0, 1'b1, 1'b0, 12'h000, 12'h010);
    write_rule(1, 1'b1, 1'b1, 12'h010, 12'h020);
    write_rule(2, 1'b1, 1'b0, 12'hF00, 12'hFFF);
    #3;
    mr = model_decode(12'h015, 1'b0, 1'b0);
    check("model 015", 32'({mr.idx, mr.dv, mr.de}), 32'(3'b110));
    mr = model_decode(12'hFFF, 1'b0, 1'b0);
    check("model FFF", 32'({mr.idx, mr.dv, mr.de}), 32'(3'b001));
    mr = model_decode(12'h00F, 1'b0, 1'b0);
    check("model 00F", 32'({mr.idx, mr.dv, mr.de}), 32'(3'b010));

    // Full back-to-back sweep.
    p0 = n_pops;
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 12'(a);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    check("sweep last FFF", 32'({resp_addr, resp_de}), 32'({12'hFFF, 1'b1}));
    @(negedge clk);
    #3;
    check("sweep pops", 32'(n_pops - p0), 32'(4096));

    // Overlapping rule: highest slot wins.
    write_rule(1, 1'b1, 1'b1, 12'h00D, 12'h020);
    req_valid = 1'b1; req_addr = 12'h00E;
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    check("prio 00E", 32'({resp_idx, resp_dv, resp_de}), 32'(3'b110));
`ifdef ADDR_DECODE_PROG_OVERLAP_CHECK_EN
    check("overlap set", 32'(cfg_overlap), 32'(1));
`else
    check("overlap tied", 32'(cfg_overlap), 32'(0));
`endif

    // Default index on miss.
    @(negedge clk);
    en_def = 1'b1; def_idx = 1'b1; req_valid = 1'b1; req_addr = 12'h800;
    @(negedge clk);
    req_valid = 1'b0; en_def = 1'b0; def_idx = 1'b0;
    #3;
    check("default 800", 32'({resp_idx, resp_dv, resp_de}), 32'(3'b100));

    // Backpressure for 5 cycles, then release.
    @(negedge clk);
    p0 = n_pops;
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 12'h011;
    repeat (5) @(negedge clk);
    #3;
    check("bp req_ready", 32'(req_ready), 32'(0));
    check("bp hold addr", 32'(resp_addr), 32'(12'h011));
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    req_addr = 12'h012;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #3;
    check("bp pops", 32'(n_pops - p0), 32'(3));

    // Disable slot0 in the same cycle as an accept.
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_en = 1'b0; cfg_idx = '0;
    cfg_start = 12'h000; cfg_end = 12'h010;
    req_valid = 1'b1; req_addr = 12'h005;
    @(negedge clk);
    cfg_we = 1'b0;
    #3;
    check("same-cycle hit", 32'({resp_idx, resp_dv, resp_de}), 32'(3'b010));
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    check("after disable", 32'({resp_idx, resp_dv, resp_de}), 32'(3'b001));

    // Out-of-range selector is ignored; an empty (reversed) range never hits.
    write_rule(3, 1'b1, 1'b1, 12'h000, 12'hFFF);
    write_rule(2, 1'b1, 1'b1, 12'h100, 12'h080);
    req_valid = 1'b1; req_addr = 12'h005;
    @(negedge clk);
    req_addr = 12'h0F0;
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    check("reversed range", 32'({resp_addr, resp_de}), 32'({12'h0F0, 1'b1}));

    // Reset mid-transfer drops the response.
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 12'h015;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async rst drop", 32'(resp_valid), 32'(0));
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    #3;
    check("post-rst no resp", 32'(resp_valid), 32'(0));
    check("post-rst overlap", 32'(cfg_overlap), 32'(0));
    check("scoreboard empty", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
